// File: rtl/frame_to_spi_pkg.sv
// Shared types, constants and the status-header builder for the SPI frame uploader.
package frame_to_spi_pkg;

    localparam int unsigned HDR_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        FRAMES,
        STREAM,
        EXHAUST
    } state_t;

    localparam logic [7:0]  CMD_START    = 8'hA5;
    localparam logic [7:0]  HDR_MAGIC    = 8'hA6;
    localparam logic [23:0] HDR_SYNC     = 24'hFFFF7F;
    localparam logic [15:0] COUNT_STREAM = 16'hFFFF;

    // Command word as received from the SPI slave
    typedef struct packed {
        logic [7:0]  op;
        logic [3:0]  ch;
        logic [1:0]  rsvd;
        logic [1:0]  width;
        logic [15:0] count;
    } cmd_t;

    function automatic logic [HDR_W-1:0] build_header(
        input logic [3:0]  ch,
        input logic [3:0]  seq,
        input logic [15:0] send_count,
        input logic [15:0] sync_count,
        input logic [7:0]  leds,
        input logic [15:0] lost_frames,
        input logic [31:0] total_frames
    );
        return {HDR_MAGIC, ch, seq, send_count, sync_count, leds,
                lost_frames, total_frames, HDR_SYNC};
    endfunction

endpackage

// File: rtl/toggle_edge_sync.sv
// Brings a toggle-style handshake into clk and turns each level change into a one-cycle pulse.
module toggle_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic toggle,
    output logic pulse_c
);

    logic [2:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], toggle};
        end
    end

    assign pulse_c = sync[2] ^ sync[1];

endmodule

// File: rtl/frame_to_spi_mux.sv
// Multi-channel SPI frame uploader: header, requested data frames, then header fill until CS rises.
module frame_to_spi_mux
    import frame_to_spi_pkg::*;
#(
    parameter int unsigned FRAME_W     = 128,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CH_LOG2     = 1,
    parameter int unsigned BUFFLENLOG2 = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [1:0]                    Width,
    output logic                          Transmitting,
    output logic [CH_LOG2-1:0]            ActiveCh,
    output logic                          CmdErr,
    input  logic [NUM_CH*FRAME_W-1:0]     Frame,
    input  logic [NUM_CH-1:0]             FrameReady,
    input  logic [NUM_CH*BUFFLENLOG2-1:0] FramesCnt,
    output logic [NUM_CH-1:0]             FrameNext,
    output logic [FRAME_W-1:0]            TxFrame,
    input  logic                          TxGetNext,
    input  logic [31:0]                   RxPacket,
    input  logic                          PktComplete,
    input  logic                          CS,
    input  logic [7:0]                    Leds,
    input  logic [15:0]                   SyncCount,
    input  logic [15:0]                   LostFrames,
    input  logic [31:0]                   TotalFrames
);

    state_t      state;
    logic [3:0]  seq;
    logic [15:0] send_count;
    logic        tx_is_data;
    logic [1:0]  cmd_width;
    logic [15:0] cmd_count;

    logic tx_ev;
    logic pk_ev;

    toggle_edge_sync u_tx_sync (
        .clk     (clk),
        .rst     (rst),
        .toggle  (TxGetNext),
        .pulse_c (tx_ev)
    );

    toggle_edge_sync u_pk_sync (
        .clk     (clk),
        .rst     (rst),
        .toggle  (PktComplete),
        .pulse_c (pk_ev)
    );

    // Per-channel views of the flattened FIFO buses
    logic [FRAME_W-1:0] frame_arr [NUM_CH];
    logic [15:0]        cnt_arr   [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign frame_arr[i] = Frame[i*FRAME_W +: FRAME_W];
        assign cnt_arr[i]   = 16'(FramesCnt[i*BUFFLENLOG2 +: BUFFLENLOG2]);
    end

    cmd_t cmd;
    logic cmd_valid;
    logic unused_rsvd;

    assign cmd         = cmd_t'(RxPacket);
    assign cmd_valid   = (cmd.op == CMD_START) && (32'(cmd.ch) < NUM_CH);
    assign unused_rsvd = ^cmd.rsvd;

    logic [15:0]        cur_cnt;
    logic [15:0]        cur_cnt_dec;
    logic               data_ok;
    logic [FRAME_W-1:0] hdr_frame;

    always_comb begin
        cur_cnt     = cnt_arr[ActiveCh];
        cur_cnt_dec = (cur_cnt == 16'd0) ? 16'd0 : cur_cnt - 16'd1;
        data_ok     = ((state == FRAMES) || (state == STREAM)) &&
                      FrameReady[ActiveCh] && (cur_cnt != 16'd0);
        hdr_frame   = '0;
        hdr_frame[FRAME_W-1 -: HDR_W] = build_header(4'(ActiveCh), seq, send_count,
                                                     SyncCount, Leds, LostFrames, TotalFrames);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            Transmitting <= 1'b0;
            Width        <= 2'd3;
            ActiveCh     <= '0;
            CmdErr       <= 1'b0;
            FrameNext    <= '0;
            TxFrame      <= '0;
            send_count   <= '0;
            seq          <= '0;
            tx_is_data   <= 1'b0;
            cmd_width    <= '0;
            cmd_count    <= '0;
        end else begin
            CmdErr     <= 1'b0;
            FrameNext  <= '0;
            TxFrame    <= data_ok ? frame_arr[ActiveCh] : hdr_frame;
            tx_is_data <= data_ok;

            // CS release ends any cluster and wins over a same-cycle shifter event
            if ((state != IDLE) && CS) begin
                state        <= IDLE;
                Transmitting <= 1'b0;
                send_count   <= cur_cnt;
            end else begin
                case (state)
                    IDLE: begin
                        if (pk_ev && !CS) begin
                            if (cmd_valid) begin
                                ActiveCh     <= cmd.ch[CH_LOG2-1:0];
                                seq          <= seq + 4'd1;
                                cmd_width    <= cmd.width;
                                cmd_count    <= cmd.count;
                                state        <= FIRST;
                                Transmitting <= 1'b1;
                            end else begin
                                CmdErr <= 1'b1;
                            end
                        end
                    end
                    FIRST: begin
                        if (tx_ev) begin
                            Width <= cmd_width;
                            if (cmd_count == 16'd0) begin
                                state      <= EXHAUST;
                                send_count <= cur_cnt;
                            end else if (cmd_count == COUNT_STREAM) begin
                                state <= STREAM;
                            end else begin
                                state      <= FRAMES;
                                send_count <= cmd_count;
                            end
                        end
                    end
                    FRAMES: begin
                        // Only a consumed data frame is popped; header underrun fill is not counted
                        if (tx_ev && tx_is_data) begin
                            FrameNext[ActiveCh] <= 1'b1;
                            if (send_count == 16'd1) begin
                                state      <= EXHAUST;
                                send_count <= cur_cnt_dec;
                            end else begin
                                send_count <= send_count - 16'd1;
                            end
                        end
                    end
                    STREAM: begin
                        send_count <= cur_cnt;
                        if (tx_ev && tx_is_data) begin
                            FrameNext[ActiveCh] <= 1'b1;
                        end
                    end
                    EXHAUST: begin
                    end
                    default: begin
                        state        <= IDLE;
                        Transmitting <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_to_spi_mux.sv
// Randomized bench: FIFO and SPI-shifter models plus a cluster-level reference of the uploaded word stream.
module tb_frame_to_spi_mux;

    localparam int unsigned FRAME_W = 128;
    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned CH_LOG2 = 1;
    localparam int unsigned BL      = 9;
    localparam int unsigned DEPTH   = 64;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [1:0]                Width;
    logic                      Transmitting;
    logic [CH_LOG2-1:0]        ActiveCh;
    logic                      CmdErr;
    logic [NUM_CH*FRAME_W-1:0] Frame;
    logic [NUM_CH-1:0]         FrameReady;
    logic [NUM_CH*BL-1:0]      FramesCnt;
    logic [NUM_CH-1:0]         FrameNext;
    logic [FRAME_W-1:0]        TxFrame;
    logic                      TxGetNext;
    logic [31:0]               RxPacket;
    logic                      PktComplete;
    logic                      CS;
    logic [7:0]                Leds;
    logic [15:0]               SyncCount;
    logic [15:0]               LostFrames;
    logic [31:0]               TotalFrames;

    frame_to_spi_mux #(
        .FRAME_W     (FRAME_W),
        .NUM_CH      (NUM_CH),
        .CH_LOG2     (CH_LOG2),
        .BUFFLENLOG2 (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Width        (Width),
        .Transmitting (Transmitting),
        .ActiveCh     (ActiveCh),
        .CmdErr       (CmdErr),
        .Frame        (Frame),
        .FrameReady   (FrameReady),
        .FramesCnt    (FramesCnt),
        .FrameNext    (FrameNext),
        .TxFrame      (TxFrame),
        .TxGetNext    (TxGetNext),
        .RxPacket     (RxPacket),
        .PktComplete  (PktComplete),
        .CS           (CS),
        .Leds         (Leds),
        .SyncCount    (SyncCount),
        .LostFrames   (LostFrames),
        .TotalFrames  (TotalFrames)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO contents per channel, consumed from head
    logic [FRAME_W-1:0] fmem [NUM_CH][DEPTH];
    int head [NUM_CH];
    int tail [NUM_CH];
    int pops [NUM_CH];
    int cmderrs;

    // Expected DUT-visible state between clusters
    int m_seq, m_sc, m_ch, m_width;

    // Current cluster bookkeeping
    int cur_ch, cur_count, cur_n, cur_base, cur_popped, cur_takes, e0;
    int p0 [NUM_CH];

    task automatic check(input string tag, input logic [FRAME_W-1:0] got,
                         input logic [FRAME_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [FRAME_W-1:0] exp_hdr(input int ch, input int seq, input int sc);
        logic [FRAME_W-1:0] h;
        h = {8'hA6, 4'(ch), 4'(seq), 16'(sc), SyncCount, Leds, LostFrames, TotalFrames, 24'hFFFF7F};
        return h;
    endfunction

    task automatic drive_fifo();
        for (int c = 0; c < NUM_CH; c++) begin
            automatic int n = tail[c] - head[c];
            FramesCnt[c*BL +: BL]          = BL'(n);
            FrameReady[c]                  = (n != 0);
            Frame[c*FRAME_W +: FRAME_W]    = (n != 0) ? fmem[c][head[c]] : '0;
        end
    endtask

    task automatic set_fifo(input int c, input int n);
        head[c] = 0;
        tail[c] = n;
        for (int i = 0; i < n; i++) fmem[c][i] = {$urandom, $urandom, $urandom, $urandom};
        drive_fifo();
    endtask

    // One clock; FIFO reacts to pop pulses and CmdErr pulses are tallied
    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (FrameNext[c]) begin
                pops[c]++;
                if (tail[c] > head[c]) head[c]++;
            end
        end
        if (CmdErr) cmderrs++;
        drive_fifo();
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cmd(input logic [7:0] op, input int ch, input int width, input int count);
        RxPacket    = {op, 4'(ch), 2'b00, 2'(width), 16'(count)};
        PktComplete = ~PktComplete;
        wait_n(8);
    endtask

    task automatic take(output logic [FRAME_W-1:0] w);
        w         = TxFrame;
        TxGetNext = ~TxGetNext;
        wait_n(8);
    endtask

    task automatic begin_cluster(input int ch, input int width, input int count);
        logic [FRAME_W-1:0] w;
        SyncCount   = 16'($urandom);
        Leds        = 8'($urandom);
        LostFrames  = 16'($urandom);
        TotalFrames = $urandom;
        cur_ch      = ch;
        cur_count   = count;
        cur_n       = tail[ch] - head[ch];
        cur_base    = head[ch];
        cur_popped  = 0;
        cur_takes   = 0;
        p0          = pops;
        e0          = cmderrs;
        CS = 1'b0;
        wait_n(2);
        check("width_hold", FRAME_W'(Width), FRAME_W'(m_width));
        send_cmd(8'hA5, ch, width, count);
        m_seq = (m_seq + 1) % 16;
        m_ch  = ch;
        check("busy", FRAME_W'(Transmitting), FRAME_W'(1));
        check("active_ch", FRAME_W'(ActiveCh), FRAME_W'(ch));
        take(w);
        check("first_hdr", w, exp_hdr(m_ch, m_seq, m_sc));
        m_width = width;
        check("width", FRAME_W'(Width), FRAME_W'(m_width));
    endtask

    task automatic take_next();
        logic [FRAME_W-1:0] w;
        logic [FRAME_W-1:0] e;
        logic is_data;
        int sc;
        is_data = 1'b0;
        sc      = 0;
        if (cur_count == 32'hFFFF) begin
            is_data = (cur_popped < cur_n);
            sc      = cur_n - cur_popped;
        end else if (cur_count == 0) begin
            sc = cur_n;
        end else if (cur_popped < cur_count && cur_popped < cur_n) begin
            is_data = 1'b1;
        end else if (cur_popped < cur_count) begin
            sc = cur_count - cur_popped;
        end else begin
            sc = cur_n - cur_count;
        end
        e = is_data ? fmem[cur_ch][cur_base + cur_popped] : exp_hdr(m_ch, m_seq, sc);
        take(w);
        cur_takes++;
        check($sformatf("take%0d_ch%0d_cnt%0d", cur_takes, cur_ch, cur_count), w, e);
        if (is_data) cur_popped++;
    endtask

    task automatic end_cluster();
        CS = 1'b1;
        wait_n(4);
        check("pops_active", FRAME_W'(pops[cur_ch] - p0[cur_ch]), FRAME_W'(cur_popped));
        check("pops_other", FRAME_W'(pops[1 - cur_ch] - p0[1 - cur_ch]), FRAME_W'(0));
        check("no_cmderr", FRAME_W'(cmderrs - e0), FRAME_W'(0));
        check("idle", FRAME_W'(Transmitting), FRAME_W'(0));
        m_sc = cur_n - cur_popped;
        check("idle_hdr", TxFrame, exp_hdr(m_ch, m_seq, m_sc));
    endtask

    task automatic run_cluster(input int ch, input int width, input int count, input int extra);
        begin_cluster(ch, width, count);
        for (int i = 0; i < extra; i++) take_next();
        end_cluster();
    endtask

    initial begin
        int e1;
        rst = 1'b1; CS = 1'b1; TxGetNext = 1'b0; PktComplete = 1'b0; RxPacket = '0;
        Leds = 8'h5A; SyncCount = 16'h1234; LostFrames = 16'h0042; TotalFrames = 32'hDEADBEEF;
        for (int c = 0; c < NUM_CH; c++) begin head[c] = 0; tail[c] = 0; pops[c] = 0; end
        cmderrs = 0;
        m_seq = 0; m_sc = 0; m_ch = 0; m_width = 3;
        set_fifo(0, 3);
        set_fifo(1, 5);
        wait_n(3);
        check("rst_txframe", TxFrame, FRAME_W'(0));
        check("rst_width", FRAME_W'(Width), FRAME_W'(3));
        rst = 1'b0;
        CS  = 1'b0;
        wait_n(20);
        check("idle_hdr0", TxFrame, exp_hdr(0, 0, 0));
        check("idle_width", FRAME_W'(Width), FRAME_W'(3));
        check("idle_busy", FRAME_W'(Transmitting), FRAME_W'(0));
        check("idle_pops", FRAME_W'(pops[0] + pops[1]), FRAME_W'(0));

        // Rejected commands, a command while CS is high, and a shifter toggle in IDLE
        e1 = cmderrs;
        send_cmd(8'h5A, 1, 2, 3);
        check("err_op", FRAME_W'(cmderrs - e1), FRAME_W'(1));
        check("err_op_idle", FRAME_W'(Transmitting), FRAME_W'(0));
        send_cmd(8'hA5, 3, 2, 3);
        check("err_ch", FRAME_W'(cmderrs - e1), FRAME_W'(2));
        check("err_ch_keep", FRAME_W'(ActiveCh), FRAME_W'(0));
        check("err_hdr", TxFrame, exp_hdr(m_ch, m_seq, m_sc));
        CS = 1'b1;
        send_cmd(8'hA5, 1, 2, 3);
        check("cs_high_cmd", FRAME_W'(Transmitting), FRAME_W'(0));
        check("cs_high_noerr", FRAME_W'(cmderrs - e1), FRAME_W'(2));
        CS = 1'b0;
        TxGetNext = ~TxGetNext;
        wait_n(8);
        check("idle_tx_ignored", FRAME_W'(pops[0] + pops[1]), FRAME_W'(0));
        check("idle_hdr1", TxFrame, exp_hdr(m_ch, m_seq, m_sc));

        // ch1 count 3 from 10 frames, 5 words taken in total
        set_fifo(0, 4);
        set_fifo(1, 10);
        run_cluster(1, 2, 3, 4);
        // Underrun: count exceeds occupancy
        set_fifo(0, 2);
        run_cluster(0, 1, 5, 4);
        // Streaming
        set_fifo(0, 2);
        set_fifo(1, 3);
        run_cluster(0, 0, 16'hFFFF, 4);
        // Count 0 reports occupancy only
        set_fifo(1, 4);
        run_cluster(1, 3, 0, 2);

        // CS rises one clock before a shifter event while data is shown
        set_fifo(0, 4);
        set_fifo(1, 2);
        begin_cluster(0, 2, 5);
        take_next();
        TxGetNext = ~TxGetNext;
        tick();
        CS = 1'b1;
        wait_n(8);
        end_cluster();

        // Randomized clusters
        for (int k = 0; k < 12; k++) begin
            int ch, n, r, count;
            ch = $urandom_range(0, 1);
            n  = $urandom_range(0, 7);
            set_fifo(ch, n);
            set_fifo(1 - ch, $urandom_range(0, 7));
            r = $urandom_range(0, 3);
            count = (r == 0) ? 0 : (r == 1) ? 32'hFFFF : $urandom_range(1, 6);
            run_cluster(ch, $urandom_range(0, 3), count, $urandom_range(0, 8));
        end

        // Sequence number wraps across 16 clusters
        for (int k = 0; k < 16; k++) begin
            set_fifo(k % 2, k % 3);
            run_cluster(k % 2, k % 4, 0, 1);
        end

        // Reset mid-FRAMES with seq 15, with a shifter event still in flight
        while (m_seq != 14) run_cluster(0, 0, 0, 0);
        set_fifo(1, 6);
        begin_cluster(1, 1, 4);
        check("seq15_hdr_seq", FRAME_W'(m_seq), FRAME_W'(15));
        take_next();
        TxGetNext = ~TxGetNext;
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_txframe", TxFrame, FRAME_W'(0));
        check("mid_rst_width", FRAME_W'(Width), FRAME_W'(3));
        check("mid_rst_busy", FRAME_W'(Transmitting), FRAME_W'(0));
        check("mid_rst_next", FRAME_W'(FrameNext), FRAME_W'(0));
        check("mid_rst_ch", FRAME_W'(ActiveCh), FRAME_W'(0));
        check("mid_rst_err", FRAME_W'(CmdErr), FRAME_W'(0));
        CS  = 1'b1;
        rst = 1'b0;
        wait_n(6);
        check("mid_rst_nopop", FRAME_W'(pops[1] - p0[1]), FRAME_W'(cur_popped));
        m_seq = 0; m_sc = 0; m_ch = 0; m_width = 3;
        check("post_rst_hdr", TxFrame, exp_hdr(0, 0, 0));
        set_fifo(0, 3);
        run_cluster(0, 1, 2, 2);
        check("post_rst_seq", FRAME_W'(m_seq), FRAME_W'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
